// File: rtl/writeback_s.sv
// Scalar write-back collector: buffers ALU and PAC results in two FIFOs and
// arbitrates them onto one registered write-back port, with PAC starvation relief.
module writeback_s #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 3,
    parameter int unsigned INDEX_W      = 5,
    parameter int unsigned DATA_W       = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               I_Stall,
    input  logic               I_ALU_Valid,
    input  logic [INDEX_W-1:0] I_ALU_Index,
    input  logic [DATA_W-1:0]  I_ALU_Data,
    input  logic               I_PAC_Valid,
    input  logic [INDEX_W-1:0] I_PAC_Index,
    input  logic [DATA_W-1:0]  I_PAC_Data,
    output logic               O_WB_Valid,
    output logic [INDEX_W-1:0] O_WB_Index,
    output logic [DATA_W-1:0]  O_WB_Data,
    output logic               O_Full,
    output logic               O_Overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SW    = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int unsigned ENT_W = INDEX_W + DATA_W;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] NEAR_C   = CNT_W'(DEPTH - 1);
    localparam logic [SW-1:0]    STARVE_C = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_ALU,
        GNT_PAC
    } grant_e;

    logic [ENT_W-1:0]   alu_mem_q [DEPTH];
    logic [ENT_W-1:0]   alu_mem_d [DEPTH];
    logic [PTR_W-1:0]   alu_wr_q, alu_wr_d, alu_rd_q, alu_rd_d;
    logic [CNT_W-1:0]   alu_cnt_q, alu_cnt_d;

    logic [ENT_W-1:0]   pac_mem_q [DEPTH];
    logic [ENT_W-1:0]   pac_mem_d [DEPTH];
    logic [PTR_W-1:0]   pac_wr_q, pac_wr_d, pac_rd_q, pac_rd_d;
    logic [CNT_W-1:0]   pac_cnt_q, pac_cnt_d;

    logic [SW-1:0]      starve_q, starve_d;
    logic               wb_valid_q, wb_valid_d;
    logic [INDEX_W-1:0] wb_index_q, wb_index_d;
    logic [DATA_W-1:0]  wb_data_q, wb_data_d;
    logic               ovf_q, ovf_d;

    grant_e             grant;
    logic               alu_empty, pac_empty;
    logic               alu_push, alu_pop, pac_push, pac_pop;
    logic [ENT_W-1:0]   alu_head, pac_head;

    assign alu_empty = (alu_cnt_q == '0);
    assign pac_empty = (pac_cnt_q == '0);
    assign alu_head  = alu_mem_q[alu_rd_q];
    assign pac_head  = pac_mem_q[pac_rd_q];

    always_comb begin : arbiter
        grant = GNT_NONE;
        if (!I_Stall) begin
            if (!alu_empty && !pac_empty) begin
                grant = (starve_q == STARVE_C) ? GNT_PAC : GNT_ALU;
            end else if (!alu_empty) begin
                grant = GNT_ALU;
            end else if (!pac_empty) begin
                grant = GNT_PAC;
            end
        end
    end

    assign alu_pop = (grant == GNT_ALU);
    assign pac_pop = (grant == GNT_PAC);
    // A full FIFO still accepts a push when its head leaves in the same cycle.
    assign alu_push = I_ALU_Valid && ((alu_cnt_q != DEPTH_C) || alu_pop);
    assign pac_push = I_PAC_Valid && ((pac_cnt_q != DEPTH_C) || pac_pop);

    always_comb begin : alu_fifo
        alu_mem_d = alu_mem_q;
        alu_wr_d  = alu_wr_q;
        alu_rd_d  = alu_rd_q;
        if (alu_push) begin
            alu_mem_d[alu_wr_q] = {I_ALU_Index, I_ALU_Data};
            alu_wr_d            = alu_wr_q + PTR_W'(1);
        end
        if (alu_pop) begin
            alu_rd_d = alu_rd_q + PTR_W'(1);
        end
        case ({alu_push, alu_pop})
            2'b10:   alu_cnt_d = alu_cnt_q + CNT_W'(1);
            2'b01:   alu_cnt_d = alu_cnt_q - CNT_W'(1);
            default: alu_cnt_d = alu_cnt_q;
        endcase
    end

    always_comb begin : pac_fifo
        pac_mem_d = pac_mem_q;
        pac_wr_d  = pac_wr_q;
        pac_rd_d  = pac_rd_q;
        if (pac_push) begin
            pac_mem_d[pac_wr_q] = {I_PAC_Index, I_PAC_Data};
            pac_wr_d            = pac_wr_q + PTR_W'(1);
        end
        if (pac_pop) begin
            pac_rd_d = pac_rd_q + PTR_W'(1);
        end
        case ({pac_push, pac_pop})
            2'b10:   pac_cnt_d = pac_cnt_q + CNT_W'(1);
            2'b01:   pac_cnt_d = pac_cnt_q - CNT_W'(1);
            default: pac_cnt_d = pac_cnt_q;
        endcase
    end

    always_comb begin : starve_next
        starve_d = starve_q;
        if (!I_Stall) begin
            if (pac_empty || pac_pop) begin
                starve_d = '0;
            end else if (alu_pop && (starve_q != STARVE_C)) begin
                starve_d = starve_q + SW'(1);
            end
        end
    end

    always_comb begin : wb_next
        wb_valid_d = wb_valid_q;
        wb_index_d = wb_index_q;
        wb_data_d  = wb_data_q;
        case (grant)
            GNT_ALU: begin
                wb_valid_d               = 1'b1;
                {wb_index_d, wb_data_d}  = alu_head;
            end
            GNT_PAC: begin
                wb_valid_d               = 1'b1;
                {wb_index_d, wb_data_d}  = pac_head;
            end
            default: begin
                if (!I_Stall) begin
                    wb_valid_d = 1'b0;
                end
            end
        endcase
        ovf_d = ovf_q | (I_ALU_Valid & ~alu_push) | (I_PAC_Valid & ~pac_push);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                alu_mem_q[i] <= '0;
                pac_mem_q[i] <= '0;
            end
            alu_wr_q   <= '0;
            alu_rd_q   <= '0;
            alu_cnt_q  <= '0;
            pac_wr_q   <= '0;
            pac_rd_q   <= '0;
            pac_cnt_q  <= '0;
            starve_q   <= '0;
            wb_valid_q <= 1'b0;
            wb_index_q <= '0;
            wb_data_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            alu_mem_q  <= alu_mem_d;
            pac_mem_q  <= pac_mem_d;
            alu_wr_q   <= alu_wr_d;
            alu_rd_q   <= alu_rd_d;
            alu_cnt_q  <= alu_cnt_d;
            pac_wr_q   <= pac_wr_d;
            pac_rd_q   <= pac_rd_d;
            pac_cnt_q  <= pac_cnt_d;
            starve_q   <= starve_d;
            wb_valid_q <= wb_valid_d;
            wb_index_q <= wb_index_d;
            wb_data_q  <= wb_data_d;
            ovf_q      <= ovf_d;
        end
    end

    assign O_WB_Valid = wb_valid_q;
    assign O_WB_Index = wb_index_q;
    assign O_WB_Data  = wb_data_q;
    assign O_Full     = (alu_cnt_q >= NEAR_C) || (pac_cnt_q >= NEAR_C);
    assign O_Overflow = ovf_q;

endmodule

// File: tb/tb_writeback_s.sv
// Bench for writeback_s: queue-based reference model feeds an expected-write-back
// scoreboard; a negedge monitor compares every DUT output cycle.
module tb_writeback_s;

    localparam int unsigned DEPTH        = 4;
    localparam int unsigned STARVE_LIMIT = 3;
    localparam int unsigned IW           = 5;
    localparam int unsigned DW           = 32;

    typedef logic [IW+DW-1:0] ent_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          I_Stall = 1'b0;
    logic          I_ALU_Valid = 1'b0;
    logic [IW-1:0] I_ALU_Index = '0;
    logic [DW-1:0] I_ALU_Data = '0;
    logic          I_PAC_Valid = 1'b0;
    logic [IW-1:0] I_PAC_Index = '0;
    logic [DW-1:0] I_PAC_Data = '0;
    logic          O_WB_Valid;
    logic [IW-1:0] O_WB_Index;
    logic [DW-1:0] O_WB_Data;
    logic          O_Full;
    logic          O_Overflow;

    writeback_s #(
        .DEPTH(DEPTH),
        .STARVE_LIMIT(STARVE_LIMIT),
        .INDEX_W(IW),
        .DATA_W(DW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .I_Stall(I_Stall),
        .I_ALU_Valid(I_ALU_Valid),
        .I_ALU_Index(I_ALU_Index),
        .I_ALU_Data(I_ALU_Data),
        .I_PAC_Valid(I_PAC_Valid),
        .I_PAC_Index(I_PAC_Index),
        .I_PAC_Data(I_PAC_Data),
        .O_WB_Valid(O_WB_Valid),
        .O_WB_Index(O_WB_Index),
        .O_WB_Data(O_WB_Data),
        .O_Full(O_Full),
        .O_Overflow(O_Overflow)
    );

    always #5 clock = ~clock;

    int   errors = 0;
    int   checks = 0;

    // Reference model state: one queue per source plus the ordered write-back stream.
    ent_t aq[$];
    ent_t pq[$];
    ent_t exp_q[$];
    int   starve = 0;
    bit   m_popped = 1'b0;
    bit   m_stalled = 1'b0;
    bit   m_full = 1'b0;
    bit   m_ovf = 1'b0;
    bit   done = 1'b0;

    always @(posedge clock or negedge reset) begin : model
        int src;
        if (!reset) begin
            aq.delete();
            pq.delete();
            starve    = 0;
            m_popped  = 1'b0;
            m_stalled = 1'b0;
            m_full    = 1'b0;
            m_ovf     = 1'b0;
        end else begin
            src       = 0;
            m_stalled = I_Stall;
            m_popped  = 1'b0;
            if (!I_Stall) begin
                if (aq.size() > 0 && pq.size() > 0)
                    src = (starve == STARVE_LIMIT) ? 2 : 1;
                else if (aq.size() > 0)
                    src = 1;
                else if (pq.size() > 0)
                    src = 2;
                if (pq.size() == 0 || src == 2)
                    starve = 0;
                else if (starve < STARVE_LIMIT)
                    starve = starve + 1;
                if (src == 1) exp_q.push_back(aq.pop_front());
                if (src == 2) exp_q.push_back(pq.pop_front());
                m_popped = (src != 0);
            end
            if (I_ALU_Valid) begin
                if (aq.size() < DEPTH) aq.push_back({I_ALU_Index, I_ALU_Data});
                else m_ovf = 1'b1;
            end
            if (I_PAC_Valid) begin
                if (pq.size() < DEPTH) pq.push_back({I_PAC_Index, I_PAC_Data});
                else m_ovf = 1'b1;
            end
            m_full = (aq.size() >= DEPTH - 1) || (pq.size() >= DEPTH - 1);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    ent_t prev = '0;
    logic prev_valid = 1'b0;
    int   exp_rd = 0;
    bit   final_done = 1'b0;

    always @(negedge clock) begin : monitor
        if (!reset) begin
            chk("rst_valid", 64'(O_WB_Valid), 64'(0));
            chk("rst_index", 64'(O_WB_Index), 64'(0));
            chk("rst_data", 64'(O_WB_Data), 64'(0));
            chk("rst_full", 64'(O_Full), 64'(0));
            chk("rst_ovf", 64'(O_Overflow), 64'(0));
            exp_rd     = exp_q.size();
            prev       = '0;
            prev_valid = 1'b0;
        end else begin
            chk("full", 64'(O_Full), 64'(m_full));
            chk("overflow", 64'(O_Overflow), 64'(m_ovf));
            if (m_stalled) begin
                chk("stall_valid", 64'(O_WB_Valid), 64'(prev_valid));
                chk("stall_hold", 64'({O_WB_Index, O_WB_Data}), 64'(prev));
            end else if (m_popped) begin
                chk("wb_valid", 64'(O_WB_Valid), 64'(1));
                if (exp_rd < exp_q.size()) begin
                    chk("wb_entry", 64'({O_WB_Index, O_WB_Data}), 64'(exp_q[exp_rd]));
                    exp_rd++;
                end
            end else begin
                chk("idle_valid", 64'(O_WB_Valid), 64'(0));
                chk("idle_hold", 64'({O_WB_Index, O_WB_Data}), 64'(prev));
            end
            prev       = {O_WB_Index, O_WB_Data};
            prev_valid = O_WB_Valid;
            if (done && !final_done) begin
                chk("drained", 64'(exp_q.size() - exp_rd), 64'(0));
                chk("model_empty", 64'(aq.size() + pq.size()), 64'(0));
                final_done = 1'b1;
            end
        end
    end

    task automatic drive(input bit av, input logic [IW-1:0] ai, input logic [DW-1:0] ad,
                         input bit pv, input logic [IW-1:0] pi, input logic [DW-1:0] pd,
                         input bit st);
        I_ALU_Valid = av;
        I_ALU_Index = ai;
        I_ALU_Data  = ad;
        I_PAC_Valid = pv;
        I_PAC_Index = pi;
        I_PAC_Data  = pd;
        I_Stall     = st;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic rand_cycles(input int n, input int pct_a, input int pct_p, input int pct_s);
        repeat (n)
            drive($urandom_range(0, 99) < pct_a, IW'($urandom_range(0, 31)), $urandom(),
                  $urandom_range(0, 99) < pct_p, IW'($urandom_range(0, 31)), $urandom(),
                  $urandom_range(0, 99) < pct_s);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);

        // single ALU result
        drive(1'b1, 5'd5, 32'h1234, 1'b0, '0, '0, 1'b0);
        idle(4);

        // PAC head waiting behind a continuous ALU stream
        drive(1'b1, 5'd1, 32'd100, 1'b1, 5'd9, 32'd900, 1'b0);
        for (int i = 1; i < 8; i++)
            drive(1'b1, IW'(i + 1), DW'(100 + i), 1'b0, '0, '0, 1'b0);
        idle(12);

        // stall with a live output and queued entries
        drive(1'b1, 5'd2, 32'h20, 1'b0, '0, '0, 1'b0);
        drive(1'b1, 5'd3, 32'h30, 1'b0, '0, '0, 1'b0);
        drive(1'b1, 5'd4, 32'h40, 1'b0, '0, '0, 1'b0);
        drive(1'b1, 5'd6, 32'h60, 1'b0, '0, '0, 1'b1);
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        idle(6);

        // fill PAC under stall, overflow on the 5th, push+pop at full
        for (int i = 0; i < 5; i++)
            drive(1'b0, '0, '0, 1'b1, IW'(10 + i), DW'(32'hF00 + i), 1'b1);
        drive(1'b0, '0, '0, 1'b1, 5'd15, 32'hFFF, 1'b0);
        idle(8);

        // same index from both sources
        drive(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB, 1'b0);
        idle(4);

        rand_cycles(400, 55, 40, 20);
        idle(12);

        // reset while both FIFOs hold entries
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b1);
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b1);
        I_ALU_Valid = 1'b0;
        I_PAC_Valid = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        I_Stall = 1'b0;
        @(negedge clock);
        idle(5);

        rand_cycles(150, 30, 30, 15);

        for (int i = 0; i < 60 && (aq.size() + pq.size()) > 0; i++) idle(1);
        idle(3);
        done = 1'b1;
        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/writeback_s.md
# writeback_s

Scalar-unit write-back collector: the producer end of the write-back path into the register file and the operand bypass buffer. It accepts results from the scalar ALU and the PAC unit, buffers each in its own FIFO, arbitrates to a single write-back port, and drives one registered index/data pair per cycle. It also raises an early full flag that the issue stage uses for back-pressure.

## Interface
- DEPTH, 4: entries per source FIFO; power of two, at least 2.
- STARVE_LIMIT, 3: number of consecutive arbitration losses by a pending PAC head after which PAC is forced to win.
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- I_Stall  in  1  downstream stall; no dequeue, outputs hold.
- I_ALU_Valid  in  1  ALU result valid.
- I_ALU_Index  in  index_t  ALU destination register index.
- I_ALU_Data  in  data_t  ALU result.
- I_PAC_Valid  in  1  PAC result valid.
- I_PAC_Index  in  index_t  PAC destination register index.
- I_PAC_Data  in  data_t  PAC result.
- O_WB_Valid  out  1  write-back strobe to the register file and bypass buffer.
- O_WB_Index  out  index_t  write-back index.
- O_WB_Data  out  data_t  write-back data.
- O_Full  out  1  either FIFO count ≥ DEPTH-1; the issue stage must stop.
- O_Overflow  out  1  sticky; a push was dropped.

## Operation
- Two independent FIFOs (ALU, PAC), each holding {index, data} and a count of 0..DEPTH. Pointers wrap modulo DEPTH.
- Push:
  - A valid input is written at the clock edge when count < DEPTH.
  - It is also written when count == DEPTH and that FIFO pops in the same cycle.
  - Otherwise the entry is dropped and O_Overflow is set. O_Overflow clears only on reset.
- Arbitration is evaluated every cycle on the FIFO heads and only when I_Stall = 0.
  - Only ALU non-empty: pop ALU.
  - Only PAC non-empty: pop PAC.
  - Both non-empty: ALU wins, unless starve_cnt == STARVE_LIMIT, in which case PAC wins.
- starve_cnt has width $clog2(STARVE_LIMIT+1) and saturates at STARVE_LIMIT.
  - It increments when both FIFOs are non-empty and ALU wins.
  - It clears when PAC wins, when the PAC FIFO is empty, or on reset.
  - It holds while I_Stall = 1.
- Output register:
  - On a pop, O_WB_Valid=1 and O_WB_Index/O_WB_Data load the popped head.
  - With no pop and I_Stall=0, O_WB_Valid=0 and index/data hold their previous values.
  - With I_Stall=1, all three outputs hold.
- Same-index results from both sources are not merged. Both are written back in arbitration order, and the later write-back wins in the register file.
- O_Full is combinational from the registered counts. The one entry of slack covers the registered issue decision.

## Timing
- Reset values:
  - O_WB_Valid=0, O_WB_Index=0, O_WB_Data=0, O_Full=0, O_Overflow=0.
  - Counts, pointers and starve_cnt are 0.
- Latency is 2 cycles from input valid to O_WB_Valid when the FIFOs are empty and there is no stall:
  - push at edge t;
  - head visible and popped at edge t+1;
  - O_WB_Valid high after edge t+1.
- Throughput is one write-back per non-stalled cycle. Both sources pushing every cycle exceeds capacity; O_Full must rise before any drop.
- A simultaneous push and pop on one FIFO leaves its count unchanged.
- I_Stall asserted mid-burst:
  - The current output holds; it is not repeated as a new strobe (downstream treats stalled cycles as not consumed).
  - Pushes continue to be accepted.
- Reset asserted mid-operation discards all buffered entries immediately (asynchronous). The first pop after deassertion is evaluated at the first clock edge.

## Test plan
- Single ALU result (idx=5, data=0x1234) with empty FIFOs → O_WB_Valid for exactly 1 cycle, 2 cycles after the push, with idx 5 / 0x1234.
- ALU pushes every cycle for 8 cycles while PAC holds 1 entry; STARVE_LIMIT=3, DEPTH=4 → order is ALU, ALU, ALU, PAC, then the remaining ALU entries. PAC is popped 4 cycles after its head becomes visible.
- I_Stall=1 for 3 cycles while 2 ALU entries are queued → outputs frozen, count stays at 2 plus new pushes. After release, the entries drain one per cycle with no loss or duplication.
- Fill PAC with 4 entries under stall → O_Full high from count 3. A 5th push is dropped and O_Overflow=1 and stays high. A push plus pop at count 4 is accepted.
- Simultaneous ALU (idx 7, 0xA) and PAC (idx 7, 0xB) pushes → write-backs idx7/0xA then idx7/0xB on consecutive cycles.
- reset pulse low while both FIFOs are half full → all outputs 0 immediately. No write-back occurs after release until new pushes arrive.
